// File: rtl/cu_pkg.sv
// Shared opcode, state and instruction-field definitions for the control unit.
package cu_pkg;

   localparam int IR_W = 24;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ALU  = 4'h1;
   localparam logic [3:0] OP_ALUI = 4'h2;
   localparam logic [3:0] OP_LD   = 4'h3;
   localparam logic [3:0] OP_ST   = 4'h4;
   localparam logic [3:0] OP_JMP  = 4'h5;
   localparam logic [3:0] OP_BRZ  = 4'h6;
   localparam logic [3:0] OP_BRN  = 4'h7;
   localparam logic [3:0] OP_BRC  = 4'h8;
   localparam logic [3:0] OP_BRV  = 4'h9;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam int OP_HI  = 23;
   localparam int OP_LO  = 20;
   localparam int FS_HI  = 19;
   localparam int FS_LO  = 16;
   localparam int TD_BIT = 15;
   localparam int DR_HI  = 14;
   localparam int DR_LO  = 12;
   localparam int TA_BIT = 11;
   localparam int SA_HI  = 10;
   localparam int SA_LO  = 8;
   localparam int TB_BIT = 7;
   localparam int SB_HI  = 6;
   localparam int SB_LO  = 4;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   // Flag register layout is {V,C,N,Z}
   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

endpackage

// File: rtl/cu_decoder.sv
// Combinational instruction decode: register fields, op class and branch condition.
// Zero latency; no handshake.
module cu_decoder
   import cu_pkg::*;
(
   input  logic [IR_W-1:0] i_ir,
   input  logic [3:0]      i_flags,
   output logic [2:0]      o_da,
   output logic [2:0]      o_aa,
   output logic [2:0]      o_ba,
   output logic            o_td,
   output logic            o_ta,
   output logic            o_tb,
   output logic [3:0]      o_fs,
   output logic [7:0]      o_imm,
   output logic            o_alu,
   output logic            o_alui,
   output logic            o_ld,
   output logic            o_st,
   output logic            o_jmp,
   output logic            o_br_taken,
   output logic            o_halt,
   output logic            o_illegal
);

   logic [3:0] w_op;
   logic       w_imm_form;

   assign w_op       = i_ir[OP_HI:OP_LO];
   assign w_imm_form = (w_op == OP_ALUI) || (w_op == OP_JMP) ||
                       (w_op == OP_BRZ) || (w_op == OP_BRN) ||
                       (w_op == OP_BRC) || (w_op == OP_BRV);

   assign o_da  = i_ir[DR_HI:DR_LO];
   assign o_td  = i_ir[TD_BIT];
   assign o_aa  = i_ir[SA_HI:SA_LO];
   assign o_ta  = i_ir[TA_BIT];
   // imm8 overlaps TB/SB, so immediate forms must not leak it onto the B select
   assign o_ba  = w_imm_form ? 3'b000 : i_ir[SB_HI:SB_LO];
   assign o_tb  = w_imm_form ? 1'b0   : i_ir[TB_BIT];
   assign o_fs  = i_ir[FS_HI:FS_LO];
   assign o_imm = i_ir[IMM_HI:IMM_LO];

   assign o_alui    = (w_op == OP_ALUI);
   assign o_alu     = (w_op == OP_ALU) || o_alui;
   assign o_ld      = (w_op == OP_LD);
   assign o_st      = (w_op == OP_ST);
   assign o_jmp     = (w_op == OP_JMP);
   assign o_halt    = (w_op == OP_HALT);
   assign o_illegal = (w_op >= 4'hA) && (w_op <= 4'hE);

   always_comb begin
      o_br_taken = 1'b0;
      case (w_op)
         OP_BRZ:  o_br_taken = i_flags[FLAG_Z];
         OP_BRN:  o_br_taken = i_flags[FLAG_N];
         OP_BRC:  o_br_taken = i_flags[FLAG_C];
         OP_BRV:  o_br_taken = i_flags[FLAG_V];
         default: o_br_taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: fetch/exec/mem FSM driving a register-file datapath.
// ALU ops take fetch + 1 cycles; LD/ST wait in MEM until dmem_ack, fetch waits on imem_ack.
module control_unit
   import cu_pkg::*;
#(
   parameter int PC_W = 8
)(
   input  logic            clk,
   input  logic            reset_n,
   output logic [PC_W-1:0] imem_addr,
   output logic            imem_req,
   input  logic [23:0]     imem_rdata,
   input  logic            imem_ack,
   output logic            dmem_re,
   output logic            dmem_we,
   input  logic            dmem_ack,
   output logic [2:0]      DA,
   output logic [2:0]      AA,
   output logic [2:0]      BA,
   output logic            TD,
   output logic            TA,
   output logic            TB,
   output logic            RW,
   output logic            MB,
   output logic            MD,
   output logic [3:0]      FS,
   output logic [7:0]      const_in,
   input  logic            V,
   input  logic            C,
   input  logic            N,
   input  logic            Z,
   output logic            halted,
   output logic            illegal
);

   state_t            r_state;
   logic [PC_W-1:0]   r_pc;
   logic [IR_W-1:0]   r_ir;
   logic [3:0]        r_flags;

   logic [7:0] w_imm;
   logic       w_alu, w_alui, w_ld, w_st, w_jmp, w_br_taken, w_halt, w_illegal;

   cu_decoder u_dec (
      .i_ir       (r_ir),
      .i_flags    (r_flags),
      .o_da       (DA),
      .o_aa       (AA),
      .o_ba       (BA),
      .o_td       (TD),
      .o_ta       (TA),
      .o_tb       (TB),
      .o_fs       (FS),
      .o_imm      (w_imm),
      .o_alu      (w_alu),
      .o_alui     (w_alui),
      .o_ld       (w_ld),
      .o_st       (w_st),
      .o_jmp      (w_jmp),
      .o_br_taken (w_br_taken),
      .o_halt     (w_halt),
      .o_illegal  (w_illegal)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= FETCH;
         r_pc    <= '0;
         r_ir    <= '0;
         r_flags <= '0;
      end else begin
         case (r_state)
            FETCH: begin
               if (imem_ack) begin
                  r_ir    <= imem_rdata;
                  r_pc    <= r_pc + PC_W'(1);
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               r_state <= FETCH;
               if (w_alu)
                  r_flags <= {V, C, N, Z};
               if (w_ld || w_st)
                  r_state <= MEM;
               if (w_halt)
                  r_state <= HALT;
               if (w_jmp || w_br_taken)
                  r_pc <= PC_W'(w_imm);
            end
            MEM: begin
               if (dmem_ack)
                  r_state <= FETCH;
            end
            HALT:    r_state <= HALT;
            default: r_state <= FETCH;
         endcase
      end
   end

   // State sits at FETCH during reset; the request must still stay low until release
   assign imem_req  = (r_state == FETCH) && reset_n;
   assign imem_addr = r_pc;

   assign dmem_re  = (r_state == MEM) && w_ld;
   assign dmem_we  = (r_state == MEM) && w_st;
   assign MD       = (r_state == MEM) && w_ld && dmem_ack;
   assign RW       = ((r_state == EXEC) && w_alu) || MD;
   assign MB       = w_alui;
   assign const_in = w_imm;
   assign halted   = (r_state == HALT);
   assign illegal  = (r_state == EXEC) && w_illegal;

endmodule

// File: tb/tb_control_unit.sv
// Scenario bench for control_unit; expected fetch addresses flow through a queue.
module tb_control_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  imem_addr;
   logic        imem_req;
   logic [23:0] imem_rdata;
   logic        imem_ack;
   logic        dmem_re, dmem_we, dmem_ack;
   logic [2:0]  DA, AA, BA;
   logic        TD, TA, TB, RW, MB, MD;
   logic [3:0]  FS;
   logic [7:0]  const_in;
   logic        V, C, N, Z;
   logic        halted, illegal;

   int          n_checks = 0;
   int          n_errs   = 0;
   logic [7:0]  m_pc;
   logic [7:0]  exp_addr_q[$];

   control_unit #(.PC_W(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
      .dmem_re(dmem_re), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .DA(DA), .AA(AA), .BA(BA), .TD(TD), .TA(TA), .TB(TB),
      .RW(RW), .MB(MB), .MD(MD), .FS(FS), .const_in(const_in),
      .V(V), .C(C), .N(N), .Z(Z), .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Enters at posedge+2 of a FETCH cycle, leaves at posedge+2 of the EXEC cycle
   task automatic do_fetch(input logic [23:0] instr);
      logic [7:0] exp;
      int n;
      n = 0;
      imem_rdata = instr;
      imem_ack   = 1'b1;
      #1;
      while (imem_req !== 1'b1 && n < 10) begin
         @(posedge clk);
         #3;
         n++;
      end
      n_checks++;
      if (imem_req !== 1'b1) begin
         n_errs++;
         $display("FAIL fetch_req: imem_req=%b required 1 within 10 cycles", imem_req);
      end
      n_checks++;
      if (exp_addr_q.size() == 0) begin
         n_errs++;
         $display("FAIL fetch_addr: imem_addr=%0h but no expected address queued", imem_addr);
      end else begin
         exp = exp_addr_q.pop_front();
         if (imem_addr !== exp) begin
            n_errs++;
            $display("FAIL fetch_addr: imem_addr=%0h required %0h", imem_addr, exp);
         end
      end
      @(posedge clk);
      #2;
      imem_ack = 1'b0;
      m_pc = m_pc + 8'd1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; imem_rdata = '0; imem_ack = 1'b0; dmem_ack = 1'b0;
      V = 1'b0; C = 1'b0; N = 1'b0; Z = 1'b0;
      tick(); tick();
      #1;
      n_checks++;
      if ({imem_req, dmem_re, dmem_we, RW, halted, illegal} !== 6'b0) begin
         n_errs++;
         $display("FAIL reset_strobes: req/re/we/rw/halted/illegal=%b required 000000",
                  {imem_req, dmem_re, dmem_we, RW, halted, illegal});
      end
      n_checks++;
      if ({DA, AA, FS, const_in} !== 18'h0) begin
         n_errs++;
         $display("FAIL reset_ir: DA=%0h AA=%0h FS=%0h const_in=%0h required all 0", DA, AA, FS, const_in);
      end
      tick();
      reset_n = 1'b1;
      m_pc = 8'h00;
      exp_addr_q.push_back(m_pc);
   endtask

   task automatic test_alui();
      do_fetch(24'h221005);
      #1;
      n_checks++;
      if ({RW, MB, MD} !== 3'b110) begin
         n_errs++;
         $display("FAIL alui_ctrl: RW/MB/MD=%b required 110", {RW, MB, MD});
      end
      n_checks++;
      if (DA !== 3'd1 || const_in !== 8'h05 || FS !== 4'h2 || TB !== 1'b0) begin
         n_errs++;
         $display("FAIL alui_fields: DA=%0h const_in=%0h FS=%0h TB=%b required 1 05 2 0", DA, const_in, FS, TB);
      end
      tick();
      exp_addr_q.push_back(m_pc);
   endtask

   task automatic test_ld();
      do_fetch(24'h302000);
      #1;
      n_checks++;
      if ({dmem_re, RW} !== 2'b00) begin
         n_errs++;
         $display("FAIL ld_exec: re/RW=%b required 00", {dmem_re, RW});
      end
      tick();
      // stray fetch acks during MEM must not reload IR
      imem_ack   = 1'b1;
      imem_rdata = 24'hFFFFFF;
      for (int k = 0; k < 4; k++) begin
         dmem_ack = (k == 3);
         #1;
         n_checks++;
         if ({dmem_re, dmem_we, RW, MD} !== {1'b1, 1'b0, (k == 3), (k == 3)}) begin
            n_errs++;
            $display("FAIL ld_mem[%0d]: re/we/RW/MD=%b required 10%b%b",
                     k, {dmem_re, dmem_we, RW, MD}, (k == 3), (k == 3));
         end
         n_checks++;
         if (DA !== 3'd2) begin
            n_errs++;
            $display("FAIL ld_hold[%0d]: DA=%0h required 2", k, DA);
         end
         if (k == 3) imem_ack = 1'b0;
         tick();
      end
      dmem_ack = 1'b0;
      #1;
      n_checks++;
      if (dmem_re !== 1'b0) begin
         n_errs++;
         $display("FAIL ld_done: dmem_re=%b required 0", dmem_re);
      end
      exp_addr_q.push_back(m_pc);
   endtask

   task automatic test_branch(input logic zin);
      do_fetch(24'h110000);
      Z = zin;
      #1;
      n_checks++;
      if ({RW, MB} !== 2'b10) begin
         n_errs++;
         $display("FAIL alu_ctrl: RW/MB=%b required 10", {RW, MB});
      end
      tick();
      Z = 1'b0;
      exp_addr_q.push_back(m_pc);
      do_fetch(24'h600040);
      #1;
      n_checks++;
      if (RW !== 1'b0) begin
         n_errs++;
         $display("FAIL brz_rw: RW=%b required 0", RW);
      end
      tick();
      if (zin) m_pc = 8'h40;
      exp_addr_q.push_back(m_pc);
   endtask

   task automatic test_pc_wrap();
      do_fetch(24'h5000FF);
      tick();
      m_pc = 8'hFF;
      exp_addr_q.push_back(m_pc);
      do_fetch(24'h000000);
      #1;
      n_checks++;
      if ({RW, dmem_re, dmem_we} !== 3'b000) begin
         n_errs++;
         $display("FAIL nop_strobes: RW/re/we=%b required 000", {RW, dmem_re, dmem_we});
      end
      tick();
      exp_addr_q.push_back(m_pc);
   endtask

   task automatic test_illegal();
      do_fetch(24'hB11000);
      #1;
      n_checks++;
      if ({illegal, RW} !== 2'b10) begin
         n_errs++;
         $display("FAIL illegal_exec: illegal/RW=%b required 10", {illegal, RW});
      end
      tick();
      #1;
      n_checks++;
      if (illegal !== 1'b0) begin
         n_errs++;
         $display("FAIL illegal_pulse: illegal=%b required 0", illegal);
      end
      exp_addr_q.push_back(m_pc);
   endtask

   task automatic test_st_reset();
      do_fetch(24'h403000);
      tick();
      #1;
      n_checks++;
      if ({dmem_we, dmem_re, RW} !== 3'b100) begin
         n_errs++;
         $display("FAIL st_mem: we/re/RW=%b required 100", {dmem_we, dmem_re, RW});
      end
      tick();
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (dmem_we !== 1'b0) begin
         n_errs++;
         $display("FAIL st_async_reset: dmem_we=%b required 0", dmem_we);
      end
      tick();
      #1;
      n_checks++;
      if ({imem_req, DA} !== 4'b0000) begin
         n_errs++;
         $display("FAIL st_in_reset: imem_req=%b DA=%0h required 0 0", imem_req, DA);
      end
      reset_n = 1'b1;
      m_pc = 8'h00;
      exp_addr_q.push_back(m_pc);
   endtask

   task automatic test_halt();
      do_fetch(24'hF00000);
      tick();
      imem_ack = 1'b1;
      for (int k = 0; k < 20; k++) begin
         #1;
         n_checks++;
         if ({imem_req, halted, dmem_re, dmem_we, RW} !== 5'b01000) begin
            n_errs++;
            $display("FAIL halt[%0d]: req/halted/re/we/RW=%b required 01000",
                     k, {imem_req, halted, dmem_re, dmem_we, RW});
         end
         tick();
      end
      imem_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_alui();
      test_ld();
      test_branch(1'b1);
      test_branch(1'b0);
      test_pc_wrap();
      test_illegal();
      test_st_reset();
      test_halt();
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
